// File: rtl/cmd_proc_pkg.sv
// Shared opcode, state and response definitions for the queued command processor.
package cmd_proc_pkg;

  typedef enum logic [2:0] {
    OP_CAL   = 3'b000,
    OP_HDNG  = 3'b001,
    OP_MOVE  = 3'b010,
    OP_SOLVE = 3'b011,
    OP_FLUSH = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    HDNG,
    MOVE,
    SOLVE
  } state_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hE5;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with combinational head word and a clear that empties it in one cycle.
module cmd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_proc_q.sv
// Queued command processor: buffers commands, dispatches one at a time, reports ACK/ERR,
// enforces a per-command timeout and honours an out-of-band FLUSH.
module cmd_proc_q
  import cmd_proc_pkg::*;
#(
  parameter int CMD_W   = 16,
  parameter int HDNG_W  = 12,
  parameter int Q_DEPTH = 4,
  parameter int TMO_CYC = 50000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CMD_W-1:0]               cmd,
  input  logic                           cmd_rdy,
  output logic                           clr_cmd_rdy,
  output logic                           send_resp,
  output logic [7:0]                     resp,
  input  logic                           cal_done,
  output logic                           strt_cal,
  output logic                           in_cal,
  input  logic                           mv_cmplt,
  output logic                           strt_hdng,
  output logic                           strt_mv,
  output logic                           stp_lft,
  output logic                           stp_rght,
  output logic [HDNG_W-1:0]              dsrd_hdng,
  input  logic                           sol_cmplt,
  output logic                           cmd_md,
  output logic                           abort,
  output logic                           busy,
  output logic [$clog2(Q_DEPTH+1)-1:0]   q_cnt
);

  localparam int TMR_W = $clog2(TMO_CYC+1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_CYC-1);

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [HDNG_W-1:0] hdng_r;
  logic [CMD_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              flush;
  logic              push;
  logic              dispatch;
  logic              done;
  logic              tmo;
  opcode_t           in_op;
  opcode_t           hd_op;

  cmd_fifo #(.W(CMD_W), .DEPTH(Q_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (dispatch),
    .clr   (flush),
    .din   (cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .cnt   (q_cnt)
  );

  assign busy   = (state != IDLE);
  assign in_cal = (state == CAL);

  // Strobes and responses are decided combinationally from the registered state; a held
  // reset suppresses every strobe so an op killed by reset never answers.
  always_comb begin
    in_op       = opcode_t'(cmd[CMD_W-1 -: 3]);
    hd_op       = opcode_t'(head[CMD_W-1 -: 3]);
    flush       = rst_n && cmd_rdy && (in_op == OP_FLUSH);
    push        = rst_n && cmd_rdy && !flush && !full;
    clr_cmd_rdy = flush || push;
    dispatch    = rst_n && (state == IDLE) && !empty && !flush;
    done        = ((state == CAL) && cal_done) ||
                  (((state == HDNG) || (state == MOVE)) && mv_cmplt) ||
                  ((state == SOLVE) && sol_cmplt);
    tmo         = busy && !done && (timer == TMO_LAST);
    state_nxt   = state;
    strt_cal    = 1'b0;
    strt_hdng   = 1'b0;
    strt_mv     = 1'b0;
    send_resp   = 1'b0;
    resp        = RESP_ACK;
    abort       = 1'b0;
    if (flush) begin
      send_resp = 1'b1;
      abort     = busy;
      state_nxt = IDLE;
    end else if (dispatch) begin
      case (hd_op)
        OP_CAL:   begin strt_cal  = 1'b1; state_nxt = CAL;   end
        OP_HDNG:  begin strt_hdng = 1'b1; state_nxt = HDNG;  end
        OP_MOVE:  begin strt_mv   = 1'b1; state_nxt = MOVE;  end
        OP_SOLVE: state_nxt = SOLVE;
        default:  begin send_resp = 1'b1; resp = RESP_ERR; end
      endcase
    end else if (rst_n && busy && done) begin
      send_resp = 1'b1;
      state_nxt = IDLE;
    end else if (rst_n && tmo) begin
      send_resp = 1'b1;
      resp      = RESP_ERR;
      abort     = 1'b1;
      state_nxt = IDLE;
    end
    cmd_md    = !rst_n || !((state == SOLVE) || (state_nxt == SOLVE));
    dsrd_hdng = (dispatch && (hd_op == OP_HDNG)) ? head[HDNG_W-1:0] : hdng_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      hdng_r   <= '0;
      stp_lft  <= 1'b0;
      stp_rght <= 1'b0;
    end else begin
      state <= state_nxt;
      if (dispatch)  timer <= '0;
      else if (busy) timer <= timer + 1'b1;
      if (dispatch && (hd_op == OP_HDNG)) hdng_r <= head[HDNG_W-1:0];
      if (dispatch && (hd_op == OP_MOVE)) begin
        stp_lft  <= head[1];
        stp_rght <= head[0];
      end else if ((state == MOVE) && (state_nxt != MOVE)) begin
        stp_lft  <= 1'b0;
        stp_rght <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_proc_q.sv
// Directed bench for cmd_proc_q: queueing, dispatch order, backpressure, flush, timeout, reserved opcode, reset.
module tb_cmd_proc_q;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        cal_done;
  logic        strt_cal;
  logic        in_cal;
  logic        mv_cmplt;
  logic        strt_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;
  logic [11:0] dsrd_hdng;
  logic        sol_cmplt;
  logic        cmd_md;
  logic        abort;
  logic        busy;
  logic [2:0]  q_cnt;

  int checks   = 0;
  int failures = 0;

  cmd_proc_q #(.CMD_W(16), .HDNG_W(12), .Q_DEPTH(4), .TMO_CYC(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .cal_done    (cal_done),
    .strt_cal    (strt_cal),
    .in_cal      (in_cal),
    .mv_cmplt    (mv_cmplt),
    .strt_hdng   (strt_hdng),
    .strt_mv     (strt_mv),
    .stp_lft     (stp_lft),
    .stp_rght    (stp_rght),
    .dsrd_hdng   (dsrd_hdng),
    .sol_cmplt   (sol_cmplt),
    .cmd_md      (cmd_md),
    .abort       (abort),
    .busy        (busy),
    .q_cnt       (q_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge, then let comb outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd = '0; cmd_rdy = 0; cal_done = 0; mv_cmplt = 0; sol_cmplt = 0;
    tick(); tick(); settle();
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b need 0", busy); end
    checks++; if (q_cnt !== 3'd0)     begin failures++; $display("FAIL reset_qcnt got %0d need 0", q_cnt); end
    checks++; if (cmd_md !== 1'b1)    begin failures++; $display("FAIL reset_cmd_md got %b need 1", cmd_md); end
    checks++; if (dsrd_hdng !== 12'h0) begin failures++; $display("FAIL reset_hdng got %h need 000", dsrd_hdng); end
    checks++; if ({send_resp, abort, in_cal, stp_lft, stp_rght, strt_cal, strt_hdng, strt_mv} !== 8'h00)
      begin failures++; $display("FAIL reset_outs got %b need 00000000",
        {send_resp, abort, in_cal, stp_lft, stp_rght, strt_cal, strt_hdng, strt_mv}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hdng();
    cmd = 16'h2123; cmd_rdy = 1; settle();
    checks++; if (clr_cmd_rdy !== 1'b1) begin failures++; $display("FAIL hdng_accept got %b need 1", clr_cmd_rdy); end
    checks++; if (strt_hdng !== 1'b0)   begin failures++; $display("FAIL hdng_no_passthru got %b need 0", strt_hdng); end
    tick(); cmd_rdy = 0; settle();
    checks++; if (strt_hdng !== 1'b1)    begin failures++; $display("FAIL hdng_strt got %b need 1", strt_hdng); end
    checks++; if (dsrd_hdng !== 12'h123) begin failures++; $display("FAIL hdng_val got %h need 123", dsrd_hdng); end
    tick(); settle();
    checks++; if (busy !== 1'b1 || strt_hdng !== 1'b0) begin failures++; $display("FAIL hdng_busy got busy=%b strt=%b need 1/0", busy, strt_hdng); end
    mv_cmplt = 1; settle();
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin failures++; $display("FAIL hdng_ack got %b/%h need 1/a5", send_resp, resp); end
    tick(); mv_cmplt = 0; settle();
    checks++; if (busy !== 1'b0 || dsrd_hdng !== 12'h123) begin failures++; $display("FAIL hdng_idle got busy=%b hdng=%h need 0/123", busy, dsrd_hdng); end
  endtask

  task automatic test_back_to_back();
    cmd = 16'h2000; cmd_rdy = 1; tick();          // HDNG keeps the processor busy
    cmd = 16'h0000; tick();
    settle();
    checks++; if (q_cnt !== 3'd1) begin failures++; $display("FAIL b2b_q1 got %0d need 1", q_cnt); end
    cmd = 16'h4003; tick(); settle();
    checks++; if (q_cnt !== 3'd2) begin failures++; $display("FAIL b2b_q2 got %0d need 2", q_cnt); end
    cmd = 16'h6000; tick(); cmd_rdy = 0; settle();
    checks++; if (q_cnt !== 3'd3) begin failures++; $display("FAIL b2b_q3 got %0d need 3", q_cnt); end
    mv_cmplt = 1; settle();
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin failures++; $display("FAIL b2b_hdng_ack got %b/%h need 1/a5", send_resp, resp); end
    tick(); mv_cmplt = 0; settle();
    checks++; if (strt_cal !== 1'b1) begin failures++; $display("FAIL b2b_strt_cal got %b need 1", strt_cal); end
    tick(); settle();
    checks++; if (in_cal !== 1'b1) begin failures++; $display("FAIL b2b_in_cal got %b need 1", in_cal); end
    cal_done = 1; settle();
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin failures++; $display("FAIL b2b_cal_ack got %b/%h need 1/a5", send_resp, resp); end
    tick(); cal_done = 0; settle();
    checks++; if (strt_mv !== 1'b1) begin failures++; $display("FAIL b2b_strt_mv got %b need 1", strt_mv); end
    tick(); settle();
    checks++; if (stp_lft !== 1'b1 || stp_rght !== 1'b1) begin failures++; $display("FAIL b2b_stp got %b%b need 11", stp_lft, stp_rght); end
    checks++; if (q_cnt !== 3'd1) begin failures++; $display("FAIL b2b_q_move got %0d need 1", q_cnt); end
    mv_cmplt = 1; settle();
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin failures++; $display("FAIL b2b_mv_ack got %b/%h need 1/a5", send_resp, resp); end
    tick(); mv_cmplt = 0; settle();
    checks++; if (stp_lft !== 1'b0 || stp_rght !== 1'b0) begin failures++; $display("FAIL b2b_stp_clr got %b%b need 00", stp_lft, stp_rght); end
    checks++; if (cmd_md !== 1'b0) begin failures++; $display("FAIL b2b_md_dispatch got %b need 0", cmd_md); end
    tick(); settle();
    checks++; if (cmd_md !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_solve got md=%b busy=%b need 0/1", cmd_md, busy); end
    sol_cmplt = 1; settle();
    checks++; if (send_resp !== 1'b1 || resp !== 8'hA5) begin failures++; $display("FAIL b2b_sol_ack got %b/%h need 1/a5", send_resp, resp); end
    tick(); sol_cmplt = 0; settle();
    checks++; if (cmd_md !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_done got md=%b busy=%b need 1/0", cmd_md, busy); end
  endtask

  task automatic test_full();
    cmd = 16'h0000; cmd_rdy = 1; tick();          // CAL dispatches and stays busy
    for (int i = 1; i <= 4; i++) begin
      cmd = 16'h2000 + 16'(i); tick();
    end
    cmd = 16'h2005; settle();
    checks++; if (q_cnt !== 3'd4)       begin failures++; $display("FAIL full_qcnt got %0d need 4", q_cnt); end
    checks++; if (clr_cmd_rdy !== 1'b0) begin failures++; $display("FAIL full_backpressure got %b need 0", clr_cmd_rdy); end
    tick(); settle();
    checks++; if (q_cnt !== 3'd4 || clr_cmd_rdy !== 1'b0) begin failures++; $display("FAIL full_hold got q=%0d clr=%b need 4/0", q_cnt, clr_cmd_rdy); end
    cal_done = 1; tick(); cal_done = 0; settle();  // idle: head pops this cycle, still full
    checks++; if (clr_cmd_rdy !== 1'b0 || strt_hdng !== 1'b1) begin failures++; $display("FAIL full_pop_cycle got clr=%b strt=%b need 0/1", clr_cmd_rdy, strt_hdng); end
    tick(); settle();
    checks++; if (q_cnt !== 3'd3 || clr_cmd_rdy !== 1'b1) begin failures++; $display("FAIL full_accept got q=%0d clr=%b need 3/1", q_cnt, clr_cmd_rdy); end
    tick(); cmd = 16'hE000; settle();
    checks++; if (q_cnt !== 3'd4 || clr_cmd_rdy !== 1'b1) begin failures++; $display("FAIL full_flush_accept got q=%0d clr=%b need 4/1", q_cnt, clr_cmd_rdy); end
    tick(); cmd_rdy = 0; settle();
    checks++; if (q_cnt !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL full_flushed got q=%0d busy=%b need 0/0", q_cnt, busy); end
  endtask

  task automatic test_flush();
    cmd = 16'h4002; cmd_rdy = 1; tick();
    cmd = 16'h0000; tick();
    cmd = 16'h6000; tick();
    cmd = 16'hE000; mv_cmplt = 1; settle();        // flush coincides with move completion
    checks++; if (q_cnt !== 3'd2) begin failures++; $display("FAIL flush_qcnt got %0d need 2", q_cnt); end
    checks++; if (stp_lft !== 1'b1 || stp_rght !== 1'b0) begin failures++; $display("FAIL flush_stp got %b%b need 10", stp_lft, stp_rght); end
    checks++; if (abort !== 1'b1 || send_resp !== 1'b1 || resp !== 8'hA5 || clr_cmd_rdy !== 1'b1)
      begin failures++; $display("FAIL flush_resp got abort=%b sr=%b resp=%h clr=%b need 1/1/a5/1", abort, send_resp, resp, clr_cmd_rdy); end
    tick(); cmd_rdy = 0; mv_cmplt = 0; settle();
    checks++; if (q_cnt !== 3'd0 || busy !== 1'b0 || abort !== 1'b0) begin failures++; $display("FAIL flush_after got q=%0d busy=%b abort=%b need 0/0/0", q_cnt, busy, abort); end
    checks++; if (stp_lft !== 1'b0 || strt_cal !== 1'b0 || send_resp !== 1'b0) begin failures++; $display("FAIL flush_quiet got stp=%b cal=%b sr=%b need 0/0/0", stp_lft, strt_cal, send_resp); end
    // Flush while idle: ACK with no abort
    cmd = 16'hE000; cmd_rdy = 1; settle();
    checks++; if (abort !== 1'b0 || send_resp !== 1'b1 || resp !== 8'hA5) begin failures++; $display("FAIL flush_idle got abort=%b sr=%b resp=%h need 0/1/a5", abort, send_resp, resp); end
    tick(); cmd_rdy = 0;
  endtask

  task automatic test_timeout();
    int early;
    for (int pass = 0; pass < 2; pass++) begin
      early = 0;
      cmd = 16'h0000; cmd_rdy = 1; tick(); cmd_rdy = 0;   // dispatch cycle
      tick();                                            // busy cycle 1
      for (int c = 1; c < 20; c++) begin
        settle();
        if (send_resp !== 1'b0 || abort !== 1'b0) early++;
        tick();
      end
      checks++; if (early !== 0) begin failures++; $display("FAIL tmo_early pass %0d got %0d responses need 0", pass, early); end
      if (pass == 1) cal_done = 1;
      settle();
      if (pass == 0) begin
        checks++; if (send_resp !== 1'b1 || resp !== 8'hE5 || abort !== 1'b1) begin failures++; $display("FAIL tmo_err got sr=%b resp=%h abort=%b need 1/e5/1", send_resp, resp, abort); end
      end else begin
        checks++; if (send_resp !== 1'b1 || resp !== 8'hA5 || abort !== 1'b0) begin failures++; $display("FAIL tmo_race got sr=%b resp=%h abort=%b need 1/a5/0", send_resp, resp, abort); end
      end
      tick(); cal_done = 0; settle();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_idle pass %0d got %b need 0", pass, busy); end
    end
  endtask

  task automatic test_reserved();
    cmd = 16'hA000; cmd_rdy = 1; tick(); cmd_rdy = 0; settle();
    checks++; if (send_resp !== 1'b1 || resp !== 8'hE5) begin failures++; $display("FAIL rsv_err got %b/%h need 1/e5", send_resp, resp); end
    checks++; if ({strt_cal, strt_hdng, strt_mv} !== 3'b000 || cmd_md !== 1'b1) begin failures++; $display("FAIL rsv_strobes got %b md=%b need 000/1", {strt_cal, strt_hdng, strt_mv}, cmd_md); end
    tick(); settle();
    checks++; if (busy !== 1'b0 || q_cnt !== 3'd0 || send_resp !== 1'b0) begin failures++; $display("FAIL rsv_idle got busy=%b q=%0d sr=%b need 0/0/0", busy, q_cnt, send_resp); end
  endtask

  task automatic test_reset_mid();
    cmd = 16'h6000; cmd_rdy = 1; tick(); cmd_rdy = 0; tick(); settle();
    checks++; if (cmd_md !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_solve got md=%b busy=%b need 0/1", cmd_md, busy); end
    rst_n = 0; sol_cmplt = 1; settle();
    checks++; if (send_resp !== 1'b0) begin failures++; $display("FAIL rstmid_noresp got %b need 0", send_resp); end
    tick(); rst_n = 1; sol_cmplt = 0; settle();
    checks++; if (cmd_md !== 1'b1 || busy !== 1'b0 || send_resp !== 1'b0) begin failures++; $display("FAIL rstmid_after got md=%b busy=%b sr=%b need 1/0/0", cmd_md, busy, send_resp); end
  endtask

  initial begin
    test_reset();
    test_hdng();
    test_back_to_back();
    test_full();
    test_flush();
    test_timeout();
    test_reserved();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
